argmax_cmd_initiator: RTL

- Initiator side of the argmax custom-instruction interface. It takes a job (row index plus N fp32 logits) and issues the instruction sequence XWR×N, START, STAT polling, RIDX and RMAX to the argmax accelerator port.
- It returns {max_idx, max_val} on a result handshake.
- It sits between a stream producer (e.g. FC output drain) and the argmax accelerator, replacing CPU-driven sequencing.

---
 rtl/argmax_cmd_initiator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/argmax_cmd_initiator.sv
// argmax_cmd_initiator: sequences XWR/START/STAT/RIDX/RMAX to the argmax accelerator for one job.
module argmax_cmd_initiator #(
  parameter int M = 8,
  parameter int N = 8,
  parameter int ROW_W = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W = (N <= 1) ? 1 : $clog2(N),
  parameter logic [4:0] RD_IDX = 5'd1,
  parameter int POLL_MAX = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [ROW_W-1:0] job_row,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [31:0]      rs1_val,
  output logic [31:0]      rs2_val,
  output logic [4:0]       rd_addr,
  input  logic             rd_we,
  input  logic [4:0]       rd_waddr,
  input  logic [31:0]      rd_wdata,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [COL_W-1:0] res_idx,
  output logic [31:0]      res_max,
  output logic             res_timeout,
  output logic             res_proto_err,
  output logic             busy
);
  localparam int PC_W = $clog2(POLL_MAX + 1);
  typedef enum logic [2:0] {IDLE, LOAD, XWR, START, POLL, RIDX, RMAX, RESP} state_t;
  state_t state, state_n;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [31:0] logit;
  logic [PC_W-1:0] poll_cnt;
  logic [2:0] funct3;
  logic acc, set_to, set_pe, unused;
  assign unused = ^rd_waddr;
  assign instr_valid = state inside {XWR, START, POLL, RIDX, RMAX};
  assign acc = instr_valid && instr_ready;
  assign in_ready = state == LOAD;
  assign job_ready = state == IDLE;
  assign busy = state != IDLE;
  assign res_valid = state == RESP;
  assign rd_addr = RD_IDX;
  assign instr = instr_valid ? {7'h05, 10'd0, funct3, (funct3[2] | funct3[1]) ? RD_IDX : 5'd0, 7'h33} : 32'd0;
  always_comb begin
    state_n = state;
    set_to = 1'b0;
    set_pe = 1'b0;
    funct3 = 3'd0;
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    case (state)
      IDLE: state_n = job_valid ? LOAD : IDLE;
      LOAD: state_n = in_valid ? XWR : LOAD;
      XWR: begin
        rs1_val = 32'({row, col});
        rs2_val = logit;
        if (acc) state_n = (col == COL_W'(N - 1)) ? START : LOAD;
      end
      START: begin
        funct3 = 3'd1;
        rs1_val = 32'(row);
        if (acc) state_n = POLL;
      end
      POLL: begin
        funct3 = 3'd2;
        if (acc) begin
          set_pe = !rd_we;
          set_to = rd_we && !(rd_wdata[1] && rd_wdata[2]) && poll_cnt == PC_W'(POLL_MAX - 1);
          state_n = (rd_we && rd_wdata[1] && rd_wdata[2]) ? RIDX : (set_pe || set_to) ? RESP : POLL;
        end
      end
      RIDX: begin
        funct3 = 3'd3;
        set_pe = acc && !rd_we;
        if (acc) state_n = rd_we ? RMAX : RESP;
      end
      RMAX: begin
        funct3 = 3'd4;
        set_pe = acc && !rd_we;
        if (acc) state_n = RESP;
      end
      RESP: state_n = res_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      logit <= '0;
      poll_cnt <= '0;
      res_idx <= '0;
      res_max <= '0;
      res_timeout <= 1'b0;
      res_proto_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && job_valid) begin
        row <= job_row;
        col <= '0;
        res_idx <= '0;
        res_max <= '0;
        res_timeout <= 1'b0;
        res_proto_err <= 1'b0;
      end
      if (state == LOAD && in_valid) logit <= in_data;
      if (state == XWR && acc && col != COL_W'(N - 1)) col <= col + 1'b1;
      if (state == START && acc) poll_cnt <= '0;
      if (state == POLL && acc) poll_cnt <= poll_cnt + 1'b1;
      if (state == RIDX && acc && rd_we) res_idx <= rd_wdata[COL_W-1:0];
      if (state == RMAX && acc && rd_we) res_max <= rd_wdata;
      if (set_to) res_timeout <= 1'b1;
      if (set_pe) res_proto_err <= 1'b1;
      // a failed job never reports a partial result
      if (set_to || set_pe) begin
        res_idx <= '0;
        res_max <= '0;
      end
    end
  end
endmodule
